// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words for the instruction memory
// write port, verifies a trailing checksum and holds the core in reset until a clean load completes.
module imem_boot_loader #(
  parameter int          MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [31:0] imem_waddress,
  output logic [31:0] imem_wdata,
  output logic        imem_wr,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, RECV, WRITE, CSUM, DONE, ERROR
  } state_t;

  state_t      state, stateNext;
  logic [15:0] wordCount;
  logic [15:0] wordIndex;
  logic [1:0]  byteIndex;
  logic [7:0]  checksum;
  logic [23:0] asmBuf;
  logic        accept;
  logic [15:0] hdrCount;
  logic [7:0]  csumFinal;
  logic [15:0] wordIndexInc;

  assign accept       = byte_valid && byte_ready;
  assign hdrCount     = {byte_in, wordCount[7:0]};
  assign csumFinal    = checksum + byte_in;
  assign wordIndexInc = wordIndex + 16'd1;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, DONE, ERROR: if (start) stateNext = HDR0;
      HDR0: if (accept) stateNext = HDR1;
      HDR1: begin
        if (accept) begin
          if (hdrCount == 16'd0)                   stateNext = CSUM;
          else if (hdrCount > 16'(MAX_WORDS))      stateNext = ERROR;
          else                                     stateNext = RECV;
        end
      end
      RECV:  if (accept && byteIndex == 2'd3) stateNext = WRITE;
      WRITE: stateNext = (wordIndexInc == wordCount) ? CSUM : RECV;
      CSUM:  if (accept) stateNext = (csumFinal == 8'd0) ? DONE : ERROR;
      default: stateNext = IDLE;
    endcase
  end

  // Outputs are registered as a decode of the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cpu_reset     <= 1'b1;
      imem_wr       <= 1'b0;
      byte_ready    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      imem_waddress <= BASE_ADDR;
      imem_wdata    <= 32'd0;
      wordCount     <= 16'd0;
      wordIndex     <= 16'd0;
      byteIndex     <= 2'd0;
      checksum      <= 8'd0;
      asmBuf        <= 24'd0;
    end else begin
      state      <= stateNext;
      byte_ready <= (stateNext == HDR0) || (stateNext == HDR1) ||
                    (stateNext == RECV) || (stateNext == CSUM);
      busy       <= (stateNext == HDR0) || (stateNext == HDR1) || (stateNext == RECV) ||
                    (stateNext == WRITE) || (stateNext == CSUM);
      done       <= (stateNext == DONE);
      error      <= (stateNext == ERROR);
      cpu_reset  <= (stateNext != DONE);
      imem_wr    <= (stateNext == WRITE);

      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            wordCount <= 16'd0;
            wordIndex <= 16'd0;
            byteIndex <= 2'd0;
            checksum  <= 8'd0;
          end
        end
        HDR0: if (accept) wordCount[7:0] <= byte_in;
        HDR1: begin
          if (accept) begin
            wordCount[15:8] <= byte_in;
            wordIndex       <= 16'd0;
            byteIndex       <= 2'd0;
            checksum        <= 8'd0;
          end
        end
        RECV: begin
          if (accept) begin
            checksum  <= csumFinal;
            byteIndex <= byteIndex + 2'd1;
            case (byteIndex)
              2'd0: asmBuf[7:0]   <= byte_in;
              2'd1: asmBuf[15:8]  <= byte_in;
              2'd2: asmBuf[23:16] <= byte_in;
              default: begin
                imem_wdata    <= {byte_in, asmBuf};
                imem_waddress <= BASE_ADDR + {14'd0, wordIndex, 2'b00};
              end
            endcase
          end
        end
        WRITE: wordIndex <= wordIndexInc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: each task drives one scenario and checks its own results.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [31:0] imem_waddress;
  logic [31:0] imem_wdata;
  logic        imem_wr;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  int passCnt = 0;
  int totalCnt = 0;

  logic [31:0] wAddr [16];
  logic [31:0] wData [16];
  int          wrCount = 0;
  int          rdyDuringWr = 0;
  logic [7:0]  stream [$];

  imem_boot_loader #(.MAX_WORDS(256), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .imem_waddress(imem_waddress), .imem_wdata(imem_wdata),
    .imem_wr(imem_wr), .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_wr) begin
      if (wrCount < 16) begin
        wAddr[wrCount] = imem_waddress;
        wData[wrCount] = imem_wdata;
      end
      wrCount = wrCount + 1;
      if (byte_ready) rdyDuringWr = rdyDuringWr + 1;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        byte_valid = 1'b0;
        @(negedge clk);
      end
    end
    byte_in = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    totalCnt++;
    if (n >= 50) $display("FAIL byte_ready_timeout byte=%h waited=%0d cycles, required ready within 50", b, n);
    else passCnt++;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_stream(input bit gaps);
    foreach (stream[i]) send_byte(stream[i], gaps);
    @(negedge clk);
  endtask

  task automatic load_basic(input logic [7:0] csum);
    stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, csum};
  endtask

  task automatic test_reset();
    @(negedge clk);
    totalCnt++;
    if ({cpu_reset, imem_wr, byte_ready, busy, done, error} !== 6'b100000) begin
      $display("FAIL reset_flags got %b, required 100000", {cpu_reset, imem_wr, byte_ready, busy, done, error});
    end else passCnt++;
    totalCnt++;
    if (imem_waddress !== 32'h0 || imem_wdata !== 32'h0) begin
      $display("FAIL reset_bus got addr=%h data=%h, required 0/0", imem_waddress, imem_wdata);
    end else passCnt++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    totalCnt++;
    if (byte_ready !== 1'b0 || cpu_reset !== 1'b1) begin
      $display("FAIL idle_hold got ready=%b cpu_reset=%b, required 0/1", byte_ready, cpu_reset);
    end else passCnt++;
  endtask

  task automatic test_basic(input bit gaps, input string tag);
    wrCount = 0;
    rdyDuringWr = 0;
    pulse_start();
    totalCnt++;
    if (busy !== 1'b1 || byte_ready !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0) begin
      $display("FAIL %s_after_start got busy=%b ready=%b cpu_reset=%b done=%b, required 1/1/1/0",
               tag, busy, byte_ready, cpu_reset, done);
    end else passCnt++;
    load_basic(8'h20);
    send_stream(gaps);
    totalCnt++;
    if (wrCount !== 2) $display("FAIL %s_write_count got %0d, required 2", tag, wrCount);
    else passCnt++;
    totalCnt++;
    if (wAddr[0] !== 32'h0 || wData[0] !== 32'h0010_0513) begin
      $display("FAIL %s_word0 got addr=%h data=%h, required 00000000/00100513", tag, wAddr[0], wData[0]);
    end else passCnt++;
    totalCnt++;
    if (wAddr[1] !== 32'h4 || wData[1] !== 32'h0020_0593) begin
      $display("FAIL %s_word1 got addr=%h data=%h, required 00000004/00200593", tag, wAddr[1], wData[1]);
    end else passCnt++;
    totalCnt++;
    if ({done, cpu_reset, error, busy} !== 4'b1000) begin
      $display("FAIL %s_final got done,cpu_reset,error,busy=%b, required 1000", tag, {done, cpu_reset, error, busy});
    end else passCnt++;
    totalCnt++;
    if (rdyDuringWr !== 0) $display("FAIL %s_ready_in_write got %0d cycles, required 0", tag, rdyDuringWr);
    else passCnt++;
  endtask

  task automatic test_restart_from_done();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    totalCnt++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || byte_ready !== 1'b1) begin
      $display("FAIL restart_clear got cpu_reset=%b done=%b ready=%b, required 1/0/1", cpu_reset, done, byte_ready);
    end else passCnt++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_empty();
    wrCount = 0;
    pulse_start();
    stream = '{8'h00, 8'h00, 8'h00};
    send_stream(1'b0);
    totalCnt++;
    if (wrCount !== 0 || done !== 1'b1 || cpu_reset !== 1'b0 || error !== 1'b0) begin
      $display("FAIL empty_ok got writes=%0d done=%b cpu_reset=%b error=%b, required 0/1/0/0",
               wrCount, done, cpu_reset, error);
    end else passCnt++;
    pulse_start();
    stream = '{8'h00, 8'h00, 8'h01};
    send_stream(1'b0);
    totalCnt++;
    if (wrCount !== 0 || error !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0) begin
      $display("FAIL empty_bad got writes=%0d error=%b cpu_reset=%b done=%b, required 0/1/1/0",
               wrCount, error, cpu_reset, done);
    end else passCnt++;
  endtask

  task automatic test_bad_checksum();
    wrCount = 0;
    pulse_start();
    load_basic(8'h21);
    send_stream(1'b0);
    totalCnt++;
    if (wrCount !== 2 || wData[1] !== 32'h0020_0593) begin
      $display("FAIL badsum_writes got count=%0d word1=%h, required 2/00200593", wrCount, wData[1]);
    end else passCnt++;
    totalCnt++;
    if ({error, done, cpu_reset} !== 3'b101) begin
      $display("FAIL badsum_final got error,done,cpu_reset=%b, required 101", {error, done, cpu_reset});
    end else passCnt++;
    repeat (3) @(negedge clk);
    totalCnt++;
    if (cpu_reset !== 1'b1 || error !== 1'b1) begin
      $display("FAIL badsum_hold got cpu_reset=%b error=%b, required 1/1", cpu_reset, error);
    end else passCnt++;
  endtask

  task automatic test_oversize();
    wrCount = 0;
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    totalCnt++;
    if ({error, byte_ready, busy, done} !== 4'b1000 || wrCount !== 0) begin
      $display("FAIL oversize got error,ready,busy,done=%b writes=%0d, required 1000/0",
               {error, byte_ready, busy, done}, wrCount);
    end else passCnt++;
  endtask

  task automatic test_reset_midload();
    wrCount = 0;
    pulse_start();
    stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10};
    foreach (stream[i]) send_byte(stream[i], 1'b0);
    totalCnt++;
    if (busy !== 1'b1) $display("FAIL midload_busy got %b, required 1", busy);
    else passCnt++;
    #1 reset = 1'b1;
    #1;
    totalCnt++;
    if ({cpu_reset, imem_wr, byte_ready, busy, done, error} !== 6'b100000 ||
        imem_waddress !== 32'h0 || imem_wdata !== 32'h0) begin
      $display("FAIL midload_reset got flags=%b addr=%h data=%h, required 100000/0/0",
               {cpu_reset, imem_wr, byte_ready, busy, done, error}, imem_waddress, imem_wdata);
    end else passCnt++;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    totalCnt++;
    if (wrCount !== 0) $display("FAIL midload_nowrite got %0d writes, required 0", wrCount);
    else passCnt++;
    test_basic(1'b0, "after_reset");
  endtask

  task automatic test_start_while_busy();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    wrCount = 0;
    pulse_start();
    load_basic(8'h20);
    for (int i = 0; i < 5; i++) send_byte(stream[i], 1'b0);
    pulse_start();
    for (int i = 5; i < 11; i++) send_byte(stream[i], 1'b0);
    @(negedge clk);
    totalCnt++;
    if (wrCount !== 2 || wData[0] !== 32'h0010_0513 || wData[1] !== 32'h0020_0593 || done !== 1'b1) begin
      $display("FAIL busy_start got writes=%0d w0=%h w1=%h done=%b, required 2/00100513/00200593/1",
               wrCount, wData[0], wData[1], done);
    end else passCnt++;
  endtask

  initial begin
    test_reset();
    test_basic(1'b0, "basic");
    test_restart_from_done();
    test_basic(1'b1, "gaps");
    test_empty();
    test_bad_checksum();
    test_oversize();
    test_reset_midload();
    test_start_while_busy();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream feeder for the multicycle RISC-V core's instruction memory (Memoria32 write port: waddress/Datain/Wr).
- Accepts a byte stream from a host link with a valid/ready handshake. Assembles little-endian 32-bit instruction words and writes them to consecutive word addresses.
- Checks a trailing checksum.
- Holds the core in reset until a load completes cleanly.

Parameters:
- MAX_WORDS, 256: largest accepted program length in words; header values above this are errors.
- BASE_ADDR, 32'h0000_0000: byte address of the first written word.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse requesting a new load.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader accepts byte_in this cycle.
- imem_waddress  output  32  instruction memory write byte address.
- imem_wdata  output  32  instruction word to write.
- imem_wr  output  1  instruction memory write strobe, one cycle per word.
- cpu_reset  output  1  drives the core's reset; high = core held.
- busy  output  1  load in progress.
- done  output  1  last load succeeded.
- error  output  1  last load failed.

Behaviour:
- Clock and reset: one clock `clk`; `reset` is asynchronous and active-high.
- Reset values:
  - state IDLE.
  - cpu_reset=1.
  - imem_wr=0, byte_ready=0, busy=0, done=0, error=0.
  - imem_waddress=BASE_ADDR, imem_wdata=0.
  - word count, byte index, word index and checksum all 0.
- Handshake: a byte is consumed at a rising edge where byte_valid && byte_ready. byte_valid without byte_ready stalls the stream with no side effect. byte_ready is a registered/state-decoded output and is high only in HDR0, HDR1, RECV and CSUM.
- Stream format: count low byte, count high byte (N, 16-bit), then 4*N payload bytes (word byte 0 first), then 1 checksum byte C. Valid iff (sum of payload bytes + C) mod 256 == 0. Header bytes are not summed.
- States:
  - IDLE: cpu_reset=1. On start -> HDR0.
  - HDR0: accept byte -> count[7:0] -> HDR1.
  - HDR1: accept byte -> count[15:8].
    - N==0 -> CSUM.
    - N>MAX_WORDS -> ERROR.
    - Otherwise -> RECV, with word index=0, byte index=0 and checksum cleared.
  - RECV: each accepted byte goes to lane byte_index (bits 8*i+7:8*i) and is added to the checksum. After the 4th byte -> WRITE.
  - WRITE: one cycle, byte_ready=0, imem_wr=1.
    - imem_waddress = BASE_ADDR + 4*word_index (32-bit wrap).
    - imem_wdata = {b3,b2,b1,b0}.
    - Then word_index+1. If equal to N -> CSUM, else RECV with byte index 0.
  - CSUM: accept byte C. If (checksum+C)[7:0]==0 -> DONE, else -> ERROR.
  - DONE: done=1, cpu_reset=0 (first low cycle is the cycle state enters DONE).
  - ERROR: error=1, cpu_reset=1.
- busy=1 in HDR0 through CSUM.
- start is honoured only in IDLE, DONE or ERROR and is ignored while busy. From DONE/ERROR, start clears done/error, sets cpu_reset=1 on the next edge, and enters HDR0.
- Words already written before an ERROR stay in memory. The core is never released after an error.
- imem_wr is never high in any state other than WRITE. Exactly N write pulses occur per successful load.
- reset asserted mid-load: immediate return to reset values. Partial data is discarded and no further writes occur.

Test Plan:
1. Basic load:
   - Stimulus: start, stream 02 00 | 13 05 10 00 | 93 05 20 00 | 20, byte_valid held high.
   - Required: two imem_wr pulses, (addr 0x0, data 0x00100513) then (addr 0x4, data 0x00200593). Then done=1, cpu_reset=0, error=0.
2. Backpressure/gaps:
   - Stimulus: same stream as scenario 1 with byte_valid toggling randomly.
   - Required: identical writes. byte_ready=0 during each WRITE cycle. No byte is lost or duplicated.
3. Empty program:
   - Stimulus: 00 00 | 00.
   - Required: zero writes, done=1, cpu_reset=0.
   - Stimulus variant: 00 00 | 01.
   - Required: error=1, cpu_reset=1.
4. Bad checksum:
   - Stimulus: scenario 1 stream with final byte 21.
   - Required: both writes occur, then error=1, done=0, cpu_reset stays 1.
5. Oversize header:
   - Stimulus: MAX_WORDS=256, header 01 01 (N=257).
   - Required: ERROR immediately after the second byte, no imem_wr, byte_ready=0.
6. Reset mid-load and restart:
   - Stimulus: assert reset after 3 payload bytes.
   - Required: all outputs at reset values within the same cycle. A new start plus the scenario 1 stream then completes normally.
   - Stimulus variant: start issued while busy.
   - Required: ignored.
